// File: rtl/game_gfx_pkg.sv
// game_gfx_pkg: shared opcodes, default geometry and state encodings for the scene sequencer
package game_gfx_pkg;
    localparam logic OP_FILL     = 1'b1;
    localparam int   DEF_H_RES   = 640;
    localparam int   DEF_V_RES   = 480;
    localparam int   DEF_X_W     = 10;
    localparam int   DEF_Y_W     = 9;
    localparam int   DEF_COLOR_W = 12;
    typedef enum logic [2:0] {
        ST_SPLASH = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ERASE  = 3'd3,
        ST_PAINT  = 3'd4
    } scene_state_t;
    typedef enum logic [1:0] {
        CMD_IDLE  = 2'd0,
        CMD_ISSUE = 2'd1,
        CMD_DRAIN = 2'd2
    } cmd_state_t;
endpackage

// File: rtl/gp_cmd_issuer.sv
// gp_cmd_issuer: registers one rectangle command and runs the en/finish handshake with the graphics processor
module gp_cmd_issuer
    import game_gfx_pkg::*;
#(
    parameter int X_W     = DEF_X_W,
    parameter int Y_W     = DEF_Y_W,
    parameter int COLOR_W = DEF_COLOR_W
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               req,
    input  logic               opcode,
    input  logic [X_W-1:0]     tl_x,
    input  logic [Y_W-1:0]     tl_y,
    input  logic [X_W-1:0]     br_x,
    input  logic [Y_W-1:0]     br_y,
    input  logic [COLOR_W-1:0] arg,
    input  logic               gp_finish,
    output logic               ack,
    output logic               gp_en,
    output logic               gp_opcode,
    output logic [X_W-1:0]     gp_tl_x,
    output logic [Y_W-1:0]     gp_tl_y,
    output logic [X_W-1:0]     gp_br_x,
    output logic [Y_W-1:0]     gp_br_y,
    output logic [COLOR_W-1:0] gp_arg
);
    cmd_state_t state;
    // req is still high in the ack cycle, so ack blocks a duplicate launch
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CMD_IDLE;
            ack       <= 1'b0;
            gp_en     <= 1'b0;
            gp_opcode <= 1'b0;
            gp_tl_x   <= '0;
            gp_tl_y   <= '0;
            gp_br_x   <= '0;
            gp_br_y   <= '0;
            gp_arg    <= '0;
        end else begin
            ack <= 1'b0;
            case (state)
                CMD_IDLE: if (req && !ack && !gp_finish) begin
                    gp_opcode <= opcode;
                    gp_tl_x   <= tl_x;
                    gp_tl_y   <= tl_y;
                    gp_br_x   <= br_x;
                    gp_br_y   <= br_y;
                    gp_arg    <= arg;
                    gp_en     <= 1'b1;
                    state     <= CMD_ISSUE;
                end
                CMD_ISSUE: if (gp_finish) begin
                    gp_en <= 1'b0;
                    state <= CMD_DRAIN;
                end
                CMD_DRAIN: if (!gp_finish) begin
                    ack   <= 1'b1;
                    state <= CMD_IDLE;
                end
                default: state <= CMD_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/bar_scene_sequencer.sv
// bar_scene_sequencer: splash, full-screen clear, then per-tick erase/paint of NUM_CH level bars
module bar_scene_sequencer
    import game_gfx_pkg::*;
#(
    parameter int H_RES   = DEF_H_RES,
    parameter int V_RES   = DEF_V_RES,
    parameter int X_W     = DEF_X_W,
    parameter int Y_W     = DEF_Y_W,
    parameter int COLOR_W = DEF_COLOR_W,
    parameter int NUM_CH  = 8,
    parameter int GAP     = 4
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  repaint_tick,
    input  logic [NUM_CH*Y_W-1:0] levels,
    input  logic [COLOR_W-1:0]    bg_color,
    input  logic [COLOR_W-1:0]    fg_color,
    input  logic                  gp_finish,
    output logic                  gp_en,
    output logic                  gp_opcode,
    output logic [X_W-1:0]        gp_tl_x,
    output logic [Y_W-1:0]        gp_tl_y,
    output logic [X_W-1:0]        gp_br_x,
    output logic [Y_W-1:0]        gp_br_y,
    output logic [COLOR_W-1:0]    gp_arg,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overrun
);
    localparam int LANE_W = H_RES / NUM_CH;
    scene_state_t state;
    logic [3:0] ch;
    logic [NUM_CH*Y_W-1:0] snap;
    logic [Y_W-1:0] lvl, lvl_c, cmd_tl_y;
    logic [X_W+3:0] x0;
    logic [X_W-1:0] cmd_tl_x, cmd_br_x;
    logic [COLOR_W-1:0] cmd_arg;
    logic req, ack, skip, last;
    always_comb begin
        lvl      = snap[ch*Y_W +: Y_W];
        lvl_c    = (lvl >= Y_W'(V_RES)) ? Y_W'(V_RES) : lvl;
        x0       = (X_W+4)'(ch) * (X_W+4)'(LANE_W);
        skip     = (state == ST_PAINT) && (lvl == '0);
        req      = (state == ST_CLEAR) || (state == ST_ERASE) || ((state == ST_PAINT) && !skip);
        last     = ch == 4'(NUM_CH - 1);
        cmd_tl_x = (state == ST_CLEAR) ? '0 : X_W'(x0);
        cmd_br_x = (state == ST_CLEAR) ? X_W'(H_RES - 1) : X_W'(x0 + (X_W+4)'(LANE_W - GAP - 1));
        cmd_tl_y = (state == ST_PAINT) ? Y_W'(V_RES) - lvl_c : '0;
        cmd_arg  = (state == ST_PAINT) ? fg_color : bg_color;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_SPLASH;
            ch         <= '0;
            snap       <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            overrun    <= repaint_tick && (state != ST_IDLE);
            case (state)
                ST_SPLASH: if (start) begin
                    state <= ST_CLEAR;
                    busy  <= 1'b1;
                end
                ST_CLEAR: if (ack) begin
                    state      <= ST_IDLE;
                    busy       <= 1'b0;
                    frame_done <= 1'b1;
                end
                ST_IDLE: if (repaint_tick) begin
                    snap  <= levels;
                    ch    <= '0;
                    state <= ST_ERASE;
                    busy  <= 1'b1;
                end
                ST_ERASE: if (ack) state <= ST_PAINT;
                ST_PAINT: if (skip || ack) begin
                    state      <= last ? ST_IDLE : ST_ERASE;
                    busy       <= !last;
                    frame_done <= last;
                    ch         <= last ? ch : ch + 4'd1;
                end
                default: state <= ST_SPLASH;
            endcase
        end
    end
    gp_cmd_issuer #(.X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W)) u_issuer (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .opcode    (OP_FILL),
        .tl_x      (cmd_tl_x),
        .tl_y      (cmd_tl_y),
        .br_x      (cmd_br_x),
        .br_y      (Y_W'(V_RES - 1)),
        .arg       (cmd_arg),
        .gp_finish (gp_finish),
        .ack       (ack),
        .gp_en     (gp_en),
        .gp_opcode (gp_opcode),
        .gp_tl_x   (gp_tl_x),
        .gp_tl_y   (gp_tl_y),
        .gp_br_x   (gp_br_x),
        .gp_br_y   (gp_br_y),
        .gp_arg    (gp_arg)
    );
endmodule

// File: tb/tb_bar_scene_sequencer.sv
// tb_bar_scene_sequencer: directed frames with a command scoreboard and a delayed-finish GP model
module tb_bar_scene_sequencer;
    localparam int NUM_CH = 8;
    localparam int X_W = 10, Y_W = 9, COLOR_W = 12;
    typedef logic [50:0] cmd_t;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, repaint_tick = 1'b0, gp_finish = 1'b0;
    logic [NUM_CH*Y_W-1:0] levels = '0;
    logic [COLOR_W-1:0] bg = 12'h123, fg = 12'hABC;
    logic gp_en, gp_opcode, busy, frame_done, overrun;
    logic [X_W-1:0] gp_tl_x, gp_br_x;
    logic [Y_W-1:0] gp_tl_y, gp_br_y;
    logic [COLOR_W-1:0] gp_arg;
    cmd_t cur, held;
    cmd_t exp_q[$];
    int n_cmp = 0, n_bad = 0, fd_cnt = 0, ov_cnt = 0, cmd_cnt = 0;
    int gp_delay = 3, gp_hold = 0;
    logic prev_en = 1'b0;

    bar_scene_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .repaint_tick(repaint_tick), .levels(levels),
        .bg_color(bg), .fg_color(fg), .gp_finish(gp_finish), .gp_en(gp_en), .gp_opcode(gp_opcode),
        .gp_tl_x(gp_tl_x), .gp_tl_y(gp_tl_y), .gp_br_x(gp_br_x), .gp_br_y(gp_br_y), .gp_arg(gp_arg),
        .busy(busy), .frame_done(frame_done), .overrun(overrun)
    );

    always #5 clk = ~clk;
    assign cur = {gp_tl_x, gp_tl_y, gp_br_x, gp_br_y, gp_arg, gp_opcode};

    function automatic cmd_t mk(int tx, int ty, int bx, int by, logic [COLOR_W-1:0] a);
        return {10'(tx), 9'(ty), 10'(bx), 9'(by), a, 1'b1};
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // 80-pixel lanes, 76 drawn; ytop < 0 means the paint is skipped
    task automatic push_lane(int c, int ytop);
        exp_q.push_back(mk(c * 80, 0, c * 80 + 75, 479, bg));
        if (ytop >= 0) exp_q.push_back(mk(c * 80, ytop, c * 80 + 75, 479, fg));
    endtask

    task automatic set_levels(input int l0, l1, l2, l3, l4, l5, l6, l7);
        levels = {9'(l7), 9'(l6), 9'(l5), 9'(l4), 9'(l3), 9'(l2), 9'(l1), 9'(l0)};
    endtask

    task automatic pulse_tick();
        @(posedge clk); #1 repaint_tick = 1'b1;
        @(posedge clk); #1 repaint_tick = 1'b0;
    endtask

    task automatic wait_fd(int target, string name);
        int k = 0;
        while (fd_cnt < target && k < 3000) begin
            @(posedge clk);
            k++;
        end
        chk(name, 64'(fd_cnt), 64'(target));
    endtask

    // graphics processor model: finish after gp_delay cycles, hold it gp_hold cycles past gp_en drop
    initial begin
        forever begin
            @(negedge clk);
            if (gp_en) begin
                repeat (gp_delay) @(posedge clk);
                #1 gp_finish = 1'b1;
                for (int k = 0; k < 50 && gp_en; k++) begin
                    @(posedge clk);
                    #1;
                end
                repeat (gp_hold) @(posedge clk);
                #1 gp_finish = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (frame_done) fd_cnt++;
        if (overrun) ov_cnt++;
        if (gp_en && !prev_en) begin
            cmd_cnt++;
            chk("finish_low_at_issue", 64'(gp_finish), 64'd0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_cmd: got %0h expected none", cur);
            end else begin
                chk($sformatf("cmd%0d", cmd_cnt), 64'(cur), 64'(exp_q.pop_front()));
            end
            held = cur;
        end else if (gp_en) begin
            chk("args_stable", 64'(cur), 64'(held));
        end
        prev_en = gp_en;
    end

    initial begin
        int k;
        repeat (3) @(posedge clk);
        #1 chk("reset_outputs", 64'({gp_en, gp_opcode, gp_tl_x, gp_tl_y, gp_br_x, gp_br_y, gp_arg,
                                     busy, frame_done, overrun}), 64'd0);
        rst = 1'b0;
        pulse_tick();
        chk("overrun_splash", 64'(overrun), 64'd1);
        // splash -> clear
        exp_q.push_back(mk(0, 0, 639, 479, bg));
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("busy_clear", 64'(busy), 64'd1);
        wait_fd(1, "clear_frame_done");
        repeat (3) @(posedge clk);
        #1 chk("clear_idle", 64'({busy, 32'(exp_q.size()), 32'(fd_cnt)}), 64'({1'b0, 32'd0, 32'd1}));
        // frame 1: clamping, zero skip, tick-to-issue latency
        set_levels(0, 100, 479, 480, 511, 1, 0, 50);
        push_lane(0, -1); push_lane(1, 380); push_lane(2, 1); push_lane(3, 0);
        push_lane(4, 0); push_lane(5, 479); push_lane(6, -1); push_lane(7, 430);
        pulse_tick();
        chk("latency_1", 64'(gp_en), 64'd0);
        @(posedge clk);
        #1 chk("latency_2", 64'(gp_en), 64'd1);
        wait_fd(2, "frame1_done");
        chk("frame1_cmds", 64'({32'(cmd_cnt), 32'(exp_q.size())}), 64'({32'd15, 32'd0}));
        // frame 2: long finish hold, overrun and level change mid-frame
        gp_hold = 5;
        set_levels(10, 20, 0, 0, 0, 0, 0, 300);
        push_lane(0, 470); push_lane(1, 460); push_lane(2, -1); push_lane(3, -1);
        push_lane(4, -1); push_lane(5, -1); push_lane(6, -1); push_lane(7, 180);
        pulse_tick();
        k = 0;
        while (cmd_cnt < 18 && k < 500) begin
            @(posedge clk);
            k++;
        end
        chk("mid_frame_reached", 64'(cmd_cnt >= 18), 64'd1);
        set_levels(200, 200, 200, 200, 200, 200, 200, 200);
        pulse_tick();
        chk("overrun_mid_frame", 64'(overrun), 64'd1);
        wait_fd(3, "frame2_done");
        repeat (60) @(posedge clk);
        #1 chk("frame2_no_extra", 64'({32'(cmd_cnt), 32'(fd_cnt)}), 64'({32'd26, 32'd3}));
        chk("overrun_count", 64'(ov_cnt), 64'd2);
        // frame 3: reset while PAINT(3) is on the bus
        gp_hold = 0;
        for (int c = 0; c < NUM_CH; c++) push_lane(c, 280);
        pulse_tick();
        k = 0;
        while (!(cmd_cnt >= 34 && gp_en) && k < 500) begin
            @(posedge clk);
            #1 k++;
        end
        chk("paint3_reached", 64'(cmd_cnt), 64'd34);
        rst = 1'b1;
        @(posedge clk);
        #1 chk("reset_mid_paint", 64'({gp_en, gp_opcode, gp_tl_x, gp_tl_y, gp_br_x, gp_br_y, gp_arg,
                                       busy, frame_done, overrun}), 64'd0);
        rst = 1'b0;
        exp_q.delete();
        pulse_tick();
        chk("overrun_after_reset", 64'(overrun), 64'd1);
        exp_q.push_back(mk(0, 0, 639, 479, bg));
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_fd(4, "clear_after_reset");
        repeat (10) @(posedge clk);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
